// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO write-port bundle shared by fifo_wr_arbiter and its environment
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 4
);
    logic [NREQ-1:0]       req_vld;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       gnt;
    logic                  flush_req;
    logic                  flush_done;
    logic                  fifo_full;
    logic                  fifo_near_full;
    logic                  fifo_wen;
    logic [DSIZE-1:0]      fifo_wdata;
    logic                  fifo_wptr_clr;

    modport master (
        input  req_vld, req_data, flush_req, fifo_full, fifo_near_full,
        output req_ack, gnt, flush_done, fifo_wen, fifo_wdata, fifo_wptr_clr
    );

    modport slave (
        output req_vld, req_data, flush_req, fifo_full, fifo_near_full,
        input  req_ack, gnt, flush_done, fifo_wen, fifo_wdata, fifo_wptr_clr
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin bounded-burst FIFO write-port arbiter with flush sequencing; WARB_STATS_EN adds stat_cnt
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 4,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
`ifdef WARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] stat_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [IW-1:0]     last;      // most recent winner; also the active grantee while in GRANT
    logic [7:0]        count;
    logic [NREQ-1:0]   gnt_q;
    logic              clr_q;

    logic [IW-1:0]     cand;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              wen;
    logic [NREQ-1:0]   ack;
    logic [DSIZE-1:0]  cur_data;

    // Round-robin search starting at last+1; walking downward lets the closest candidate win.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = last;
        cand     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % NREQ);
            if (bus.req_vld[cand]) begin
                pick_any = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Write strobe and data path for the granted requester; flush and full both veto the write.
    always_comb begin
        cur_data  = bus.req_data[int'(last)*DSIZE +: DSIZE];
        wen       = (state == GRANT) && bus.req_vld[last] && !bus.fifo_full && !bus.flush_req;
        ack       = '0;
        ack[last] = wen;
    end

    assign bus.fifo_wen      = wen;
    assign bus.fifo_wdata    = (state == GRANT) ? cur_data : '0;
    assign bus.req_ack       = ack;
    assign bus.gnt           = gnt_q;
    assign bus.fifo_wptr_clr = clr_q;
    assign bus.flush_done    = clr_q;

    // Arbitration FSM: IDLE picks a winner, GRANT streams up to BURST words, FLUSH issues one clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= IW'(NREQ - 1);
            count <= '0;
            gnt_q <= '0;
            clr_q <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        state <= FLUSH;
                        clr_q <= 1'b1;
                    end else if (pick_any && !bus.fifo_near_full) begin
                        state <= GRANT;
                        gnt_q <= NREQ'(1) << pick_idx;
                        last  <= pick_idx;
                        count <= '0;
                    end
                end
                GRANT: begin
                    if (bus.flush_req) begin
                        state <= FLUSH;
                        gnt_q <= '0;
                        clr_q <= 1'b1;
                    end else if (!bus.req_vld[last]) begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end else if (wen) begin
                        count <= count + 8'd1;
                        if (count == 8'(BURST - 1)) begin
                            state <= IDLE;
                            gnt_q <= '0;
                        end
                    end
                end
                FLUSH: begin
                    // A flush_req seen here is absorbed; the pointer clear has already been issued.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

`ifdef WARB_STATS_EN
    logic [15:0] stat_q [NREQ];

    // Per-requester accepted-word counters, saturating, wiped by reset and by a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
        end else if (state == FLUSH) begin
            for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && (stat_q[i] != 16'hFFFF)) stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
    end

    // Flatten counters onto the output bus, requester i at bits [i*16 +: 16].
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) stat_cnt[i*16 +: 16] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 4;
    localparam int BURST = 4;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

`ifdef WARB_STATS_EN
    logic [NREQ*16-1:0] stat_cnt;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master)
`ifdef WARB_STATS_EN
        ,
        .stat_cnt (stat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic            rst_before;
        logic [NREQ-1:0] vld;
        logic            full;
        logic            nf;
        logic            flush;
        logic [NREQ-1:0] gnt;
        logic            wen;
        logic            clr;
    } row_t;

    row_t             rows [$];
    logic [DSIZE-1:0] word [NREQ];
    logic [DSIZE-1:0] sb [$];
    int               total;
    int               bad;

    task automatic add(input logic rb, input logic [NREQ-1:0] v, input logic f, input logic n,
                       input logic fl, input logic [NREQ-1:0] g, input logic w, input logic c);
        row_t r;
        r.rst_before = rb;
        r.vld        = v;
        r.full       = f;
        r.nf         = n;
        r.flush      = fl;
        r.gnt        = g;
        r.wen        = w;
        r.clr        = c;
        rows.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DSIZE +: DSIZE] = word[i];
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.req_vld        = '0;
        bus.fifo_full      = 1'b0;
        bus.fifo_near_full = 1'b0;
        bus.flush_req      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic run_row(input row_t r, input int idx);
        logic [NREQ-1:0]  ack_seen;
        logic [DSIZE-1:0] exp_d;
        logic [NREQ-1:0]  exp_ack;
        if (r.rst_before) do_reset();
        bus.req_vld        = r.vld;
        bus.fifo_full      = r.full;
        bus.fifo_near_full = r.nf;
        bus.flush_req      = r.flush;
        drive_data();
        if (r.wen) begin
            for (int i = 0; i < NREQ; i++) if (r.gnt[i]) sb.push_back(word[i]);
        end
        exp_ack = r.wen ? r.gnt : '0;
        @(negedge clk);
        check($sformatf("row%0d gnt", idx), 32'(bus.gnt), 32'(r.gnt));
        check($sformatf("row%0d fifo_wen", idx), 32'(bus.fifo_wen), 32'(r.wen));
        check($sformatf("row%0d req_ack", idx), 32'(bus.req_ack), 32'(exp_ack));
        check($sformatf("row%0d wptr_clr", idx), 32'(bus.fifo_wptr_clr), 32'(r.clr));
        check($sformatf("row%0d flush_done", idx), 32'(bus.flush_done), 32'(r.clr));
        if (r.gnt == '0) check($sformatf("row%0d wdata_idle", idx), 32'(bus.fifo_wdata), 32'(0));
        if (bus.fifo_wen) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL row%0d unexpected write: got wdata %0h expected no write", idx, bus.fifo_wdata);
            end else begin
                exp_d = sb.pop_front();
                check($sformatf("row%0d wdata", idx), 32'(bus.fifo_wdata), 32'(exp_d));
            end
        end
        ack_seen = bus.req_ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (ack_seen[i]) word[i] = word[i] + DSIZE'(1);
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        rst                = 1'b1;
        bus.req_vld        = '0;
        bus.fifo_full      = 1'b0;
        bus.fifo_near_full = 1'b0;
        bus.flush_req      = 1'b0;
        for (int i = 0; i < NREQ; i++) word[i] = DSIZE'(i * 4 + 1);
        drive_data();

        @(posedge clk);
        #1;
        check("reset gnt", 32'(bus.gnt), 32'(0));
        check("reset fifo_wen", 32'(bus.fifo_wen), 32'(0));
        check("reset req_ack", 32'(bus.req_ack), 32'(0));
        check("reset wptr_clr", 32'(bus.fifo_wptr_clr), 32'(0));
        check("reset flush_done", 32'(bus.flush_done), 32'(0));
        check("reset wdata", 32'(bus.fifo_wdata), 32'(0));
        rst = 1'b0;

        // single requester 2: two bursts of four with one bubble between
        add(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 0);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < BURST; k++) add(0, 4'b0100, 0, 0, 0, 4'b0100, 1, 0);
            add(0, (b == 0) ? 4'b0100 : 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
        end

        // fairness: all requesting, order 0,1,2,3,0
        add(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < BURST; k++) add(0, 4'b1111, 0, 0, 0, NREQ'(1) << (r % NREQ), 1, 0);
            add(0, (r == 4) ? 4'b0000 : 4'b1111, 0, 0, 0, 4'b0000, 0, 0);
        end

        // near-full hold-off, then release by req_vld drop
        add(1, 4'b0011, 0, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0011, 0, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0011, 0, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0011, 0, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b0011, 0, 1, 0, 4'b0001, 1, 0);
        add(0, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);

        // full stall on the second word of a burst
        add(1, 4'b0010, 0, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 4'b0010, 1, 0, 0, 4'b0010, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 0);
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);

        // flush after two words; flush_req held into FLUSH is absorbed
        add(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 0, 0, 4'b0001, 1, 0);
        add(0, 4'b1111, 0, 0, 0, 4'b0001, 1, 0);
        add(0, 4'b1111, 0, 0, 1, 4'b0001, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 4'b0000, 0, 1);
        add(0, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 0, 0, 4'b0010, 1, 0);
        add(0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);

        for (int i = 0; i < rows.size(); i++) run_row(rows[i], i);
        check("scoreboard drained", 32'(sb.size()), 32'(0));

        // asynchronous reset in the middle of a burst
        do_reset();
        bus.req_vld = 4'b1111;
        drive_data();
        @(posedge clk);
        #1;
        check("pre-rst gnt", 32'(bus.gnt), 32'(4'b0001));
        check("pre-rst wen", 32'(bus.fifo_wen), 32'(1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst gnt", 32'(bus.gnt), 32'(0));
        check("async rst wen", 32'(bus.fifo_wen), 32'(0));
        check("async rst ack", 32'(bus.req_ack), 32'(0));
        check("async rst wdata", 32'(bus.fifo_wdata), 32'(0));
`ifdef WARB_STATS_EN
        check("async rst stat_cnt", 32'(stat_cnt == '0), 32'(1));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst idle gnt", 32'(bus.gnt), 32'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post-rst first gnt", 32'(bus.gnt), 32'(4'b0001));
        check("post-rst first ack", 32'(bus.req_ack), 32'(4'b0001));
        @(posedge clk);
        #1;
        bus.req_vld = '0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
